conv3x3_seq_ctrl: RTL and testbench
===================================

Name: conv3x3_seq_ctrl

Overview:
- Sequencer and configuration front-end for the 3-row PE multiplier array (three 1-D PEs, 3 taps each, per-row results summed into Y1..Y3).
- Holds the 9 kernel weights, streams one 3-row strip of an image column-by-column into the array, and drives the 2-bit tap-phase select.
- Picks the completed window sum out of Y1..Y3 and emits it as a valid-qualified output stream, then pulses done.

Parameters:
- IMG_W, 64, maximum strip width in columns.
- PE_LAT, 3, cycles from a column entering the array (pe_en high) to its contribution being visible on pe_y*.
- DW, 8, pixel and weight width.
- OW, 16, result width.
- CW, $clog2(IMG_W+1), column-counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cfg_we  in  1  weight write strobe
- cfg_addr  in  4  weight index 0..8, row-major (0=w11 .. 8=w33)
- cfg_data  in  DW  weight value
- start  in  1  begin one strip
- img_w  in  CW  columns in this strip, sampled at start
- busy  out  1  strip in progress
- done  out  1  one-cycle pulse at end of strip
- err  out  1  sticky: start was issued with img_w<3 or img_w>IMG_W; cleared by the next accepted start
- pix_valid  in  1  column available
- pix_ready  out  1  controller accepts a column
- pix_r1, pix_r2, pix_r3  in  DW each  column pixels, rows 1..3
- pe_en  out  1  array advance enable
- pe_clr  out  1  array accumulator clear
- pe_sel  out  2  tap phase 0..2
- pe_r1, pe_r2, pe_r3  out  DW each  registered column pixels to the array
- pe_w  out  9*DW  weights, w11 in bits [DW-1:0]
- pe_y1, pe_y2, pe_y3  in  OW each  array results
- out_valid  out  1  completed window
- out_data  out  OW  window sum
- out_col  out  CW  index of the window's last column (2..img_w-1)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; weights 0; err 0.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE -> CLEAR on start when 3<=img_w<=IMG_W; capture img_w. Out-of-range img_w sets err and the FSM stays in IDLE.
- CLEAR: one cycle with pe_clr=1. Column counter col<=0 and pe_sel<=0. Then go to STREAM.
- STREAM: pix_ready=1. A column is accepted when pix_valid && pix_ready.
  - Next cycle: pe_en=1 and pe_r*=captured pixels; pe_sel is the phase of that column (col mod 3).
  - After an accept, pe_sel advances 0->1->2->0 and col increments.
  - Cycles with no accept: pe_en=0, pe_sel holds, pe_r* hold.
  - Accepting column img_w-1 moves the FSM to DRAIN and drops pix_ready in the same cycle.
- Result tracking: for each accepted column c>=2, a token {c, c mod 3} enters a PE_LAT+1 deep delay line, aligned with the pe_en cycle plus PE_LAT.
  - When a token exits: out_valid=1, out_col=c, out_data=pe_y[(c mod 3)+1], registered. Output latency from accept to out_valid is PE_LAT+2 cycles.
  - The output has no backpressure; the consumer must sink every beat.
- DRAIN: wait until the delay line is empty, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in CLEAR, STREAM, DRAIN and DONE.
- Exactly img_w-2 out_valid beats per strip.
- Arithmetic: summing is done in the array. The controller only selects and registers, with no truncation beyond OW.
- Weights:
  - A write lands the cycle after cfg_we, in IDLE only.
  - Writes while busy, or with cfg_addr>8, are ignored.
  - pe_w is driven straight from the weight registers.
- start while busy is ignored, and err is not set.
- reset_n low mid-strip: everything returns to reset values immediately. Weights reset to 0 and the delay line is flushed.

Decomposition:
- Shared package conv_pkg: FSM state enum, KERNEL_TAPS=9, NUM_PHASES=3, weight index constants.
- One sub-module ctrl_delay_line: a parameterised depth/width shift register with a valid bit, used for the result-token pipe. The remainder of the logic stays flat in this module.

Test Plan:
- All weights 1, all pixels 1, img_w=5, pix_valid held high -> 3 beats, out_col=2,3,4, out_data=9 each. First beat PE_LAT+2 cycles after the column-2 accept. done pulses once, one cycle after the delay line empties.
- Only w22=1, pix_r2=column index 0..5, img_w=6 -> out_data=1,2,3,4 (window centre).
- Same as the previous case with pix_valid toggled 1/0 -> identical data. pe_sel holds during bubbles and pe_en is low exactly on bubble cycles.
- start with img_w=2 -> err=1, busy stays 0. Then start with img_w=3 -> err clears and exactly 1 beat is produced.
- cfg_we to addr 9, and to addr 0 while busy -> pe_w unchanged. Write addr 4 =0x7F in IDLE -> pe_w[39:32]=0x7F the next cycle.
- reset_n asserted in STREAM at column 3 of 8 -> all outputs 0 and state IDLE. No stale out_valid after release. A fresh strip produces correct results.

Source files
------------

// File: rtl/conv3x3_seq_ctrl_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer: FSM encoding,
// kernel geometry and weight register indices (row-major, w11 first).
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int KERNEL_TAPS = 9;
  localparam int NUM_PHASES  = 3;

  localparam int W11_IDX = 0;
  localparam int W12_IDX = 1;
  localparam int W13_IDX = 2;
  localparam int W21_IDX = 3;
  localparam int W22_IDX = 4;
  localparam int W23_IDX = 5;
  localparam int W31_IDX = 6;
  localparam int W32_IDX = 7;
  localparam int W33_IDX = 8;

  function automatic logic [1:0] next_phase(input logic [1:0] p);
    return (p == 2'(NUM_PHASES - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/conv3x3_seq_ctrl_delay_line.sv
// Fixed-depth shift register carrying a valid bit alongside each data word;
// occupied reports whether any stage still holds a live entry.
module ctrl_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             occupied
);

  logic [DEPTH-1:0] valid_reg;
  logic [WIDTH-1:0] data_reg [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) data_reg[i] <= '0;
    end else begin
      valid_reg[0] <= in_valid;
      data_reg[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        data_reg[i]  <= data_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_data  = data_reg[DEPTH-1];
  assign occupied  = |valid_reg;

endmodule

// File: rtl/conv3x3_seq_ctrl.sv
// Sequencer for the 3-row PE array: holds the kernel, streams one 3-row strip
// column by column, and picks each finished window sum off the array outputs.
module conv3x3_seq_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int PE_LAT = 3,
  parameter int DW     = 8,
  parameter int OW     = 16,
  parameter int CW     = $clog2(IMG_W + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_we,
  input  logic [3:0]                cfg_addr,
  input  logic [DW-1:0]             cfg_data,
  input  logic                      start,
  input  logic [CW-1:0]             img_w,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [DW-1:0]             pix_r1,
  input  logic [DW-1:0]             pix_r2,
  input  logic [DW-1:0]             pix_r3,
  output logic                      pe_en,
  output logic                      pe_clr,
  output logic [1:0]                pe_sel,
  output logic [DW-1:0]             pe_r1,
  output logic [DW-1:0]             pe_r2,
  output logic [DW-1:0]             pe_r3,
  output logic [KERNEL_TAPS*DW-1:0] pe_w,
  input  logic [OW-1:0]             pe_y1,
  input  logic [OW-1:0]             pe_y2,
  input  logic [OW-1:0]             pe_y3,
  output logic                      out_valid,
  output logic [OW-1:0]             out_data,
  output logic [CW-1:0]             out_col
);

  // Token = {column index, phase}; the phase picks which array output holds the sum.
  localparam int TOK_W = CW + 2;

  state_t        state_reg, state_next;
  logic [CW-1:0] img_w_reg;
  logic [CW-1:0] col_reg;
  logic [1:0]    phase_reg;
  logic          err_reg;
  logic [DW-1:0] weight_reg [KERNEL_TAPS];

  logic             start_ok;
  logic             accept;
  logic             last_col;
  logic             cfg_hit;
  logic             tok_in_valid;
  logic [TOK_W-1:0] tok_in;
  logic             tok_out_valid;
  logic [TOK_W-1:0] tok_out;
  logic             dl_occupied;

  assign start_ok     = (img_w >= CW'(3)) && (img_w <= CW'(IMG_W));
  assign pix_ready    = (state_reg == ST_STREAM);
  assign accept       = pix_valid && pix_ready;
  assign last_col     = (col_reg == img_w_reg - CW'(1));
  assign cfg_hit      = (state_reg == ST_IDLE) && cfg_we && (cfg_addr <= 4'(W33_IDX));
  assign tok_in_valid = accept && (col_reg >= CW'(2));
  assign tok_in       = {col_reg, phase_reg};
  assign err          = err_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    pe_clr     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start && start_ok) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        pe_clr     = 1'b1;
        state_next = ST_STREAM;
      end
      ST_STREAM: if (accept && last_col) state_next = ST_DRAIN;
      ST_DRAIN:  if (!dl_occupied) state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      img_w_reg <= '0;
      col_reg   <= '0;
      phase_reg <= '0;
      err_reg   <= 1'b0;
      pe_en     <= 1'b0;
      pe_sel    <= '0;
      pe_r1     <= '0;
      pe_r2     <= '0;
      pe_r3     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_col   <= '0;
      for (int i = 0; i < KERNEL_TAPS; i++) weight_reg[i] <= '0;
    end else begin
      pe_en     <= accept;
      out_valid <= tok_out_valid;

      if (state_reg == ST_IDLE && start) begin
        if (start_ok) begin
          img_w_reg <= img_w;
          err_reg   <= 1'b0;
        end else begin
          err_reg   <= 1'b1;
        end
      end

      if (cfg_hit) weight_reg[cfg_addr] <= cfg_data;

      if (state_reg == ST_CLEAR) begin
        col_reg   <= '0;
        phase_reg <= '0;
        pe_sel    <= '0;
      end

      // pe_sel carries the phase of the column now on pe_r*, and holds through bubbles.
      if (accept) begin
        pe_r1     <= pix_r1;
        pe_r2     <= pix_r2;
        pe_r3     <= pix_r3;
        pe_sel    <= phase_reg;
        phase_reg <= next_phase(phase_reg);
        col_reg   <= col_reg + CW'(1);
      end

      if (tok_out_valid) begin
        out_col <= tok_out[TOK_W-1:2];
        case (tok_out[1:0])
          2'd0:    out_data <= pe_y1;
          2'd1:    out_data <= pe_y2;
          default: out_data <= pe_y3;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < KERNEL_TAPS; gi++) begin : g_pe_w
      assign pe_w[gi*DW +: DW] = weight_reg[gi];
    end
  endgenerate

  // One extra stage beyond PE_LAT lines the token up with the array's settled output.
  ctrl_delay_line #(
    .DEPTH (PE_LAT + 1),
    .WIDTH (TOK_W)
  ) u_tok_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (tok_in_valid),
    .in_data   (tok_in),
    .out_valid (tok_out_valid),
    .out_data  (tok_out),
    .occupied  (dl_occupied)
  );

endmodule

// File: tb/tb_conv3x3_seq_ctrl.sv
// Directed bench for conv3x3_seq_ctrl with a behavioural 3-phase PE array model
// driven by the controller's pe_* outputs.
module tb_conv3x3_seq_ctrl;
  import conv_pkg::*;

  localparam int IMG_W  = 64;
  localparam int PE_LAT = 3;
  localparam int DW     = 8;
  localparam int OW     = 16;
  localparam int CW     = $clog2(IMG_W + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          start = 1'b0;
  logic [CW-1:0] img_w = '0;
  logic          busy, done, err;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] pix_r1 = '0, pix_r2 = '0, pix_r3 = '0;
  logic          pe_en, pe_clr;
  logic [1:0]    pe_sel;
  logic [DW-1:0] pe_r1, pe_r2, pe_r3;
  logic [9*DW-1:0] pe_w;
  logic [OW-1:0] pe_y1, pe_y2, pe_y3;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_col;

  always #5 clk = ~clk;

  conv3x3_seq_ctrl #(.IMG_W(IMG_W), .PE_LAT(PE_LAT), .DW(DW), .OW(OW), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .img_w(img_w), .busy(busy), .done(done), .err(err),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r1(pix_r1), .pix_r2(pix_r2), .pix_r3(pix_r3),
    .pe_en(pe_en), .pe_clr(pe_clr), .pe_sel(pe_sel),
    .pe_r1(pe_r1), .pe_r2(pe_r2), .pe_r3(pe_r3), .pe_w(pe_w),
    .pe_y1(pe_y1), .pe_y2(pe_y2), .pe_y3(pe_y3),
    .out_valid(out_valid), .out_data(out_data), .out_col(out_col)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Array model: accumulator k owns windows ending on columns with phase k.
  logic [OW-1:0] acc_m [3];
  logic [OW-1:0] d1_m  [3];
  logic [OW-1:0] d2_m  [3];

  function automatic logic [OW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [OW-1:0] x;
    x = OW'(a);
    return x * OW'(b);
  endfunction

  function automatic logic [OW-1:0] tap(input int k);
    return mul(pe_w[k*DW +: DW], pe_r1) + mul(pe_w[(k+3)*DW +: DW], pe_r2)
         + mul(pe_w[(k+6)*DW +: DW], pe_r3);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        acc_m[i] <= '0;
        d1_m[i]  <= '0;
        d2_m[i]  <= '0;
      end
    end else begin
      if (pe_clr) begin
        for (int i = 0; i < 3; i++) acc_m[i] <= '0;
      end else if (pe_en) begin
        acc_m[int'(pe_sel)]           <= acc_m[int'(pe_sel)] + tap(2);
        acc_m[(int'(pe_sel) + 1) % 3] <= acc_m[(int'(pe_sel) + 1) % 3] + tap(1);
        acc_m[(int'(pe_sel) + 2) % 3] <= tap(0);
      end
      for (int i = 0; i < 3; i++) begin
        d1_m[i] <= acc_m[i];
        d2_m[i] <= d1_m[i];
      end
    end
  end

  assign pe_y1 = d2_m[0];
  assign pe_y2 = d2_m[1];
  assign pe_y3 = d2_m[2];

  int beat_data[$];
  int beat_col[$];
  int beat_cyc[$];
  int acc_cyc[$];

  always @(negedge clk) begin
    if (out_valid) begin
      beat_data.push_back(int'(out_data));
      beat_col.push_back(int'(out_col));
      beat_cyc.push_back(cyc);
      $display("[TB] beat col=%0d data=%0d cycle=%0d", out_col, out_data, cyc);
    end
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_w(input int addr, input int data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_data = DW'(data);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Streams ncols of an n-column strip; when ncols==n also waits for done and checks timing.
  task automatic run_strip(input int n, input int mode, input bit toggle, input bit chk_pe,
                           input int ncols);
    int  col = 0;
    int  k = 0;
    int  last_sel = 0;
    int  dcnt = 0;
    int  dcyc = 0;
    bit  accepted;
    beat_data.delete(); beat_col.delete(); beat_cyc.delete(); acc_cyc.delete();
    @(negedge clk);
    img_w = CW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (col < ncols && k < 400) begin
      pix_valid = toggle ? (k % 2 == 0) : 1'b1;
      pix_r1    = (mode == 0) ? 8'd1 : 8'h55;
      pix_r2    = (mode == 0) ? 8'd1 : DW'(col);
      pix_r3    = (mode == 0) ? 8'd1 : 8'h55;
      accepted  = pix_valid && pix_ready;
      if (accepted) acc_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      if (chk_pe) begin
        check("pe_en", 72'(pe_en), 72'(accepted));
        if (accepted) begin
          check("pe_sel", 72'(pe_sel), 72'(col % 3));
          check("pe_r2", 72'(pe_r2), 72'(col));
          last_sel = col % 3;
        end else begin
          check("pe_sel_hold", 72'(pe_sel), 72'(last_sel));
        end
      end
      if (accepted) col++;
      k++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    if (k >= 400) check("stream_timeout", 72'(col), 72'(ncols));
    if (ncols == n) begin
      repeat (40) begin
        if (done) begin
          dcnt++;
          dcyc = cyc;
        end
        @(negedge clk);
      end
      check("done_pulses", 72'(dcnt), 72'(1));
      check("done_lat", 72'(dcyc - acc_cyc[acc_cyc.size()-1]), 72'(PE_LAT + 3));
      check("beat_count", 72'(beat_data.size()), 72'(n - 2));
      if (beat_data.size() > 0)
        check("first_lat", 72'(beat_cyc[0] - acc_cyc[2]), 72'(PE_LAT + 2));
      check("busy_end", 72'(busy), 72'(0));
    end
  endtask

  task automatic check_beats(input string tag, input int n, input int fixed);
    for (int i = 0; i < beat_data.size() && i < n - 2; i++) begin
      check({tag, "_data"}, 72'(beat_data[i]), 72'((fixed != 0) ? fixed : i + 1));
      check({tag, "_col"}, 72'(beat_col[i]), 72'(i + 2));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctl", 72'({busy, done, err, pix_ready, pe_en, pe_clr, pe_sel, out_valid}), 72'(0));
    check("reset_pe_w", 72'(pe_w), 72'(0));
    check("reset_out", 72'({out_data, out_col, pe_r1, pe_r2, pe_r3}), 72'(0));
    reset_n = 1'b1;

    // All ones kernel and pixels, 5 columns
    for (int i = 0; i < 9; i++) write_w(i, 1);
    @(negedge clk);
    check("w_all_ones", 72'(pe_w), {9{8'h01}});
    run_strip(5, 0, 1'b0, 1'b0, 5);
    check_beats("ones", 5, 9);

    // Centre tap only, ramp on row 2
    for (int i = 0; i < 9; i++) write_w(i, 0);
    write_w(W22_IDX, 1);
    run_strip(6, 1, 1'b0, 1'b0, 6);
    check_beats("ramp", 6, 0);

    // Same with bubbles on pix_valid
    run_strip(6, 1, 1'b1, 1'b1, 6);
    check_beats("bubble", 6, 0);

    // Out-of-range widths, then the minimum legal width
    @(negedge clk); img_w = CW'(65); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("err_wide", 72'(err), 72'(1));
    check("busy_wide", 72'(busy), 72'(0));
    run_strip(3, 1, 1'b0, 1'b0, 3);
    check("err_cleared", 72'(err), 72'(0));
    check_beats("min_w", 3, 0);
    @(negedge clk); img_w = CW'(2); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("err_narrow", 72'(err), 72'(1));
    check("busy_narrow", 72'(busy), 72'(0));

    // Weight port boundary cases
    write_w(9, 8'hEE);
    check("cfg_addr9", 72'(pe_w), 72'h01 << 32);
    write_w(W22_IDX, 8'h7F);
    check("cfg_w22", 72'(pe_w[39:32]), 72'h7F);
    write_w(W22_IDX, 1);

    // Mid-strip: busy writes and starts are ignored, then async reset
    run_strip(8, 1, 1'b0, 1'b0, 4);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 8'hAA;
    img_w = CW'(2); start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    check("busy_write", 72'(pe_w), 72'h01 << 32);
    check("busy_start_err", 72'(err), 72'(0));
    check("busy_mid", 72'(busy), 72'(1));
    #2 reset_n = 1'b0;
    #1;
    check("rst_ctl", 72'({busy, done, err, pix_ready, pe_en, pe_clr, pe_sel, out_valid}), 72'(0));
    check("rst_out", 72'({out_data, out_col}), 72'(0));
    check("rst_pe_w", 72'(pe_w), 72'(0));
    check("rst_state", 72'(dut.state_reg), 72'(ST_IDLE));
    beat_data.delete(); beat_col.delete(); beat_cyc.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_stale_beat", 72'(beat_data.size()), 72'(0));

    // Fresh strip after reset
    write_w(W22_IDX, 1);
    run_strip(6, 1, 1'b0, 1'b0, 6);
    check_beats("post_rst", 6, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
